mmss_countdown_controller: RTL and testbench
============================================

# mmss_countdown_controller

Minutes:seconds countdown controller with alarm. It consumes the one-cycle `Pulse` tick from the general countdown timer (configured for a 1 Hz tick) and keeps a BCD MM:SS count. It provides start/pause/load control, a completion strobe and a timed alarm. Its outputs drive the seven-segment display decoders and the alarm LED/buzzer logic.

## Interface
Parameters:
- `AlarmTicks`, default 10: number of `Tick` pulses the alarm stays asserted (1..255).

Ports:
- `Clock` in 1: system clock; all logic on its rising edge.
- `Reset` in 1: synchronous, active-high; one clock, no other clock domains.
- `Tick` in 1: one-cycle time-base pulse, driven directly from the countdown timer's `Pulse`.
- `Start` in 1: one-cycle start/pause/acknowledge strobe, debounced upstream.
- `Load` in 1: one-cycle strobe that loads `SetMin`/`SetSec`.
- `SetMin` in 8: BCD minutes, {tens, ones}, 00..99.
- `SetSec` in 8: BCD seconds, {tens, ones}, 00..59.
- `MinBCD` out 8: current BCD minutes.
- `SecBCD` out 8: current BCD seconds.
- `Running` out 1: high while in RUN.
- `Done` out 1: one-cycle strobe when the count reaches 00:00 from a run.
- `Alarm` out 1: high while in ALARM.

## Operation
- States: IDLE, RUN, PAUSE, ALARM. All outputs are registered.
- Reset: state IDLE, `MinBCD`=`SecBCD`=8'h00, `Running`=`Done`=`Alarm`=0, alarm tick counter 0.

Load:
- Accepted in any state.
- Each digit is clamped on load: any digit >9 becomes 9; seconds-tens >5 becomes 5.
- State goes to IDLE and `Alarm` clears.
- `Load` has priority over `Start` and `Tick` in the same cycle.

IDLE:
- `Start` with a count ≠ 00:00 → RUN.
- `Start` at 00:00 → stays in IDLE.
- `Tick` is ignored.

RUN:
- Each `Tick` decrements the count by one second.
- When the decrement produces 00:00: state → ALARM, and `Done`=1 for exactly that cycle.
- `Start` → PAUSE.
- `Start` and `Tick` in the same cycle: the decrement is applied, then the state goes to PAUSE. If that decrement reaches 00:00, ALARM wins and `Done` fires.

PAUSE:
- `Tick` is ignored and the count is held.
- `Start` → RUN.

ALARM:
- `Alarm`=1.
- The alarm counter counts `Tick` pulses. On the `AlarmTicks`-th tick → IDLE with `Alarm`=0.
- `Start` → IDLE immediately (acknowledge).
- The count stays at 00:00.

BCD decrement, one step per `Tick`:
- Seconds-ones 0 → 9, with a borrow from seconds-tens.
- Seconds-tens 0 under a borrow → 5, with a borrow from minutes-ones.
- Minutes-ones 0 under a borrow → 9, with a borrow from minutes-tens.
- The count never decrements below 00:00; no wrap to 99:59 is allowed.
- Outputs are always valid BCD.

## Timing
- Latency is 1 cycle from any input strobe to its effect on the outputs. Example: a `Tick` at edge N gives the new count, visible after edge N.
- `Done` is asserted in the same cycle the count first shows 00:00 and the state shows ALARM.
- `Running` is high the cycle after the `Start` edge.
- Strobes are assumed to be single-cycle. A strobe held high is re-sampled every cycle, so a held `Start` toggles RUN/PAUSE every cycle.
- Reset mid-operation, from any state, returns to the full reset values on the next edge. A `Tick` in the reset cycle is lost.

## Test plan
- Reset, then Load 01:00 and Start, then 1 Tick → 00:59; 59 more Ticks → 00:00, `Done` high for 1 cycle, `Alarm`=1, `Running`=0.
- Load 10:00, Start, 1 Tick → 09:59. This checks the borrow across all four digits.
- Load 00:05, Start, 2 Ticks (00:03), Start → PAUSE; 3 Ticks → count stays 00:03; Start, 3 Ticks → 00:00 with `Done`.
- Alarm with `AlarmTicks`=3: `Alarm` drops exactly on the 3rd Tick after `Done`. In a second run, Start during ALARM clears `Alarm` next cycle and the state is IDLE.
- Load 8'hA7 min / 8'h7C sec → 97:59. Start at 00:00 (IDLE) → no state change, `Running`=0.
- Simultaneous events:
  - Load and Start in the same cycle → loads and stays in IDLE.
  - Start and Tick at 00:01 in RUN → 00:00, ALARM, `Done`=1.
  - Reset during RUN → 00:00, all outputs 0 next cycle.

Source files
------------

// File: rtl/mmss_countdown_controller.sv
// BCD MM:SS countdown with start/pause/load control and a timed alarm.
// All outputs are registered; one tick of the 1 Hz time base decrements one second.
module mmss_countdown_controller #(
  parameter int AlarmTicks = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic       Load,
  input  logic [7:0] SetMin,
  input  logic [7:0] SetSec,
  output logic [7:0] MinBCD,
  output logic [7:0] SecBCD,
  output logic       Running,
  output logic       Done,
  output logic       Alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  localparam logic [7:0] ALM_LAST = 8'(AlarmTicks - 1);

  state_t     state_q;
  logic [7:0] min_q, sec_q, alm_cnt_q;
  logic       run_q, done_q, alarm_q;

  logic [7:0] min_dec_d, sec_dec_d, min_ld_d, sec_ld_d;
  logic       dec_zero_d, cnt_zero_d;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  always_comb begin
    min_ld_d = {clamp_digit(SetMin[7:4], 4'd9), clamp_digit(SetMin[3:0], 4'd9)};
    sec_ld_d = {clamp_digit(SetSec[7:4], 4'd5), clamp_digit(SetSec[3:0], 4'd9)};
  end

  // Borrow chain across the four digits; 00:00 saturates rather than wrapping.
  always_comb begin
    min_dec_d = min_q;
    sec_dec_d = sec_q;
    if (sec_q[3:0] != 4'd0) begin
      sec_dec_d[3:0] = sec_q[3:0] - 4'd1;
    end else if (sec_q[7:4] != 4'd0) begin
      sec_dec_d = {sec_q[7:4] - 4'd1, 4'd9};
    end else if (min_q != 8'h00) begin
      sec_dec_d = 8'h59;
      if (min_q[3:0] != 4'd0) min_dec_d[3:0] = min_q[3:0] - 4'd1;
      else                    min_dec_d = {min_q[7:4] - 4'd1, 4'd9};
    end
  end

  assign dec_zero_d = (min_dec_d == 8'h00) && (sec_dec_d == 8'h00);
  assign cnt_zero_d = (min_q == 8'h00) && (sec_q == 8'h00);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      alm_cnt_q <= 8'd0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Load) begin
        min_q     <= min_ld_d;
        sec_q     <= sec_ld_d;
        state_q   <= IDLE;
        run_q     <= 1'b0;
        alarm_q   <= 1'b0;
        alm_cnt_q <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (Start && !cnt_zero_d) begin
              state_q <= RUN;
              run_q   <= 1'b1;
            end
          end
          RUN: begin
            if (Tick) begin
              min_q <= min_dec_d;
              sec_q <= sec_dec_d;
            end
            // Reaching zero beats a simultaneous pause request.
            if (Tick && dec_zero_d) begin
              state_q   <= ALARM;
              run_q     <= 1'b0;
              done_q    <= 1'b1;
              alarm_q   <= 1'b1;
              alm_cnt_q <= 8'd0;
            end else if (Start) begin
              state_q <= PAUSE;
              run_q   <= 1'b0;
            end
          end
          PAUSE: begin
            if (Start) begin
              state_q <= RUN;
              run_q   <= 1'b1;
            end
          end
          ALARM: begin
            if (Start) begin
              state_q   <= IDLE;
              alarm_q   <= 1'b0;
              alm_cnt_q <= 8'd0;
            end else if (Tick) begin
              if (alm_cnt_q == ALM_LAST) begin
                state_q   <= IDLE;
                alarm_q   <= 1'b0;
                alm_cnt_q <= 8'd0;
              end else begin
                alm_cnt_q <= alm_cnt_q + 8'd1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            alarm_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MinBCD  = min_q;
  assign SecBCD  = sec_q;
  assign Running = run_q;
  assign Done    = done_q;
  assign Alarm   = alarm_q;

endmodule

// File: tb/tb_mmss_countdown_controller.sv
// Directed bench for mmss_countdown_controller; expected outputs are queued per step
// and compared one edge later.
module tb_mmss_countdown_controller;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Tick = 1'b0, Start = 1'b0, Load = 1'b0;
  logic [7:0] SetMin = 8'h00, SetSec = 8'h00;
  logic [7:0] MinBCD, SecBCD;
  logic       Running, Done, Alarm;

  int n_eval = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [7:0] m, s;
    logic       r, d, a;
  } exp_t;
  exp_t sb[$];

  mmss_countdown_controller #(.AlarmTicks(3)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .Load(Load),
    .SetMin(SetMin), .SetSec(SetSec), .MinBCD(MinBCD), .SecBCD(SecBCD),
    .Running(Running), .Done(Done), .Alarm(Alarm)
  );

  always #5 Clock = ~Clock;

  // Integer seconds to BCD {MM, SS}, independent of the digit-borrow logic.
  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input string fld, input logic [7:0] got, input logic [7:0] exp);
    n_eval++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s.%s got %h expected %h", tag, fld, got, exp);
    end
  endtask

  // Drive one cycle of strobes, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic ld, input logic st, input logic tk,
                      input logic [15:0] set, input logic [15:0] cnt,
                      input logic r, input logic d, input logic a);
    exp_t e;
    sb.push_back('{tag, cnt[15:8], cnt[7:0], r, d, a});
    Load = ld; Start = st; Tick = tk;
    SetMin = set[15:8]; SetSec = set[7:0];
    @(posedge Clock);
    #1;
    Load = 1'b0; Start = 1'b0; Tick = 1'b0;
    e = sb.pop_front();
    chk(e.tag, "MinBCD", MinBCD, e.m);
    chk(e.tag, "SecBCD", SecBCD, e.s);
    chk(e.tag, "Running", {7'd0, Running}, {7'd0, e.r});
    chk(e.tag, "Done", {7'd0, Done}, {7'd0, e.d});
    chk(e.tag, "Alarm", {7'd0, Alarm}, {7'd0, e.a});
  endtask

  initial begin
    // Reset
    Reset = 1'b1;
    step("reset", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    Reset = 1'b0;

    // 01:00 full countdown
    step("ld0100", 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
    step("st0100", 0, 1, 0, 16'h0000, 16'h0100, 1, 0, 0);
    step("idle_run", 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0);
    for (int i = 59; i >= 1; i--)
      step("tick01", 0, 0, 1, 16'h0000, to_bcd(i), 1, 0, 0);
    step("tick_zero", 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);
    step("done_1cyc", 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step("alm_t1", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1);
    step("alm_gap", 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    step("alm_t2", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1);
    step("alm_t3", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);

    // Borrow across all four digits
    step("ld1000", 1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
    step("st1000", 0, 1, 0, 16'h0000, 16'h1000, 1, 0, 0);
    step("borrow4", 0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0);

    // Pause / resume
    step("ld0005", 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0);
    step("st0005", 0, 1, 0, 16'h0000, 16'h0005, 1, 0, 0);
    step("t_04", 0, 0, 1, 16'h0000, 16'h0004, 1, 0, 0);
    step("t_03", 0, 0, 1, 16'h0000, 16'h0003, 1, 0, 0);
    step("pause", 0, 1, 0, 16'h0000, 16'h0003, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("pause_hold", 0, 0, 1, 16'h0000, 16'h0003, 0, 0, 0);
    step("resume", 0, 1, 0, 16'h0000, 16'h0003, 1, 0, 0);
    step("t_02", 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0);
    step("t_01", 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
    step("t_00", 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);
    step("ack", 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("idle_tick", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);

    // Clamp and start at zero
    step("clamp", 1, 0, 0, 16'hA77C, 16'h9759, 0, 0, 0);
    step("ld0000", 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("st_zero", 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);

    // Load beats Start; IDLE ignores Tick
    step("ld_st", 1, 1, 0, 16'h0010, 16'h0010, 0, 0, 0);
    step("idle_ign", 0, 0, 1, 16'h0000, 16'h0010, 0, 0, 0);

    // Start+Tick reaching zero, then Load clears alarm
    step("ld0002", 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
    step("st0002", 0, 1, 0, 16'h0000, 16'h0002, 1, 0, 0);
    step("t_0001", 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
    step("st_tk_zero", 0, 1, 1, 16'h0000, 16'h0000, 0, 1, 1);
    step("ld_in_alm", 1, 0, 1, 16'h0030, 16'h0030, 0, 0, 0);

    // Start+Tick mid-count pauses after decrement; reset mid-run
    step("ld0500", 1, 0, 0, 16'h0500, 16'h0500, 0, 0, 0);
    step("st0500", 0, 1, 0, 16'h0000, 16'h0500, 1, 0, 0);
    step("t_0459", 0, 0, 1, 16'h0000, 16'h0459, 1, 0, 0);
    step("st_tk_pause", 0, 1, 1, 16'h0000, 16'h0458, 0, 0, 0);
    step("resume2", 0, 1, 0, 16'h0000, 16'h0458, 1, 0, 0);
    Reset = 1'b1;
    step("rst_run", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    Reset = 1'b0;
    step("post_rst", 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
